// File: rtl/result_deskew_collector_pkg.sv
// result_deskew_collector_pkg: shared constants and types for the GEMM result collector
package gemm_pkg;
  localparam int N = 4;
  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;
  typedef logic [3:0] addr_t;
  typedef logic [1:0] row_t;
endpackage

// File: rtl/result_deskew_collector_if.sv
// result_deskew_collector_if: skewed result lanes, control and read port of the collector
interface result_deskew_collector_if #(parameter int WIDTH = 32);
  import gemm_pkg::*;
  logic             start;
  logic             in_valid;
  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] d2;
  logic [WIDTH-1:0] d3;
  logic             rd_en;
  addr_t            rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic             busy;
  logic             done;
  modport master (output start, in_valid, d0, d1, d2, d3, rd_en, rd_addr,
                  input rd_data, busy, done);
  modport slave (input start, in_valid, d0, d1, d2, d3, rd_en, rd_addr,
                 output rd_data, busy, done);
endinterface

// File: rtl/result_deskew_collector_skew_delay.sv
// skew_delay: DEPTH-stage delay line with sync active-low reset and sync flush; DEPTH=0 is a wire
module skew_delay #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  if (DEPTH == 0) begin : g_pass
    assign q_o = d_i;
  end else begin : g_pipe
    logic [WIDTH-1:0] pipe_q [DEPTH];
    // shift every cycle; reset or flush empties every stage
    always_ff @(posedge clk) begin
      if (!rst_n || flush_i) begin
        for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
      end else begin
        pipe_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end
    assign q_o = pipe_q[DEPTH-1];
  end
endmodule

// File: rtl/result_deskew_collector.sv
// result_deskew_collector: de-skews 4 systolic result lanes into a 16-word row-major buffer
// Define GEMM_ACCUM_EN to accumulate row writes into the buffer instead of overwriting.
module result_deskew_collector
  import gemm_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic                    clk,
  input logic                    rst_n,
  result_deskew_collector_if.slave bus
);
  state_t           state_q;
  row_t             row_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] rd_data_q;
  logic [WIDTH-1:0] mem_q   [16];
  logic [WIDTH-1:0] lane_in [N];
  logic [WIDTH-1:0] lane_al [N];
  logic [WIDTH-1:0] wdata_d [N];
  logic             v_al;

  assign lane_in = '{bus.d0, bus.d1, bus.d2, bus.d3};

  genvar k;
  for (k = 0; k < N - 1; k++) begin : g_lane
    skew_delay #(.DEPTH(N - 1 - k), .WIDTH(WIDTH)) u_dly (
      .clk(clk), .rst_n(rst_n), .flush_i(bus.start), .d_i(lane_in[k]), .q_o(lane_al[k])
    );
  end
  assign lane_al[N-1] = lane_in[N-1];

  skew_delay #(.DEPTH(N - 1), .WIDTH(1)) u_vld (
    .clk(clk), .rst_n(rst_n), .flush_i(bus.start), .d_i(bus.in_valid), .q_o(v_al)
  );

  // word value written for each lane of the current row
  always_comb begin
    for (int i = 0; i < N; i++) begin
`ifdef GEMM_ACCUM_EN
      wdata_d[i] = mem_q[{row_q, 2'(i)}] + lane_al[i];
`else
      wdata_d[i] = lane_al[i];
`endif
    end
  end

  // control FSM, row writes and registered read port; start wins over a same-cycle row write
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      row_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_data_q <= '0;
      for (int a = 0; a < 16; a++) mem_q[a] <= '0;
    end else begin
      if (bus.rd_en) rd_data_q <= mem_q[bus.rd_addr];
      if (bus.start) begin
        state_q <= COLLECT;
        row_q   <= '0;
        busy_q  <= 1'b1;
        done_q  <= 1'b0;
      end else if (state_q == COLLECT && v_al) begin
        for (int i = 0; i < N; i++) mem_q[{row_q, 2'(i)}] <= wdata_d[i];
        row_q <= row_q + 2'd1;
        if (row_q == 2'd3) begin
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
      end
    end
  end

  assign bus.rd_data = rd_data_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
endmodule

// File: tb/tb_result_deskew_collector.sv
// tb_result_deskew_collector: directed checks of de-skew, FSM, restart, reset and read port
module tb_result_deskew_collector;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  result_deskew_collector_if #(.WIDTH(32)) bus();
  result_deskew_collector #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int errs = 0;
  int checks = 0;
  logic        vq  [64];
  logic [31:0] lq  [64][4];
  logic        done_log [64];
  logic        busy_log [64];
  logic [31:0] exp_mem [16];
  int          m_row;
  logic        m_act;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    for (int c = 0; c < 64; c++) begin
      vq[c] = 1'b0;
      for (int j = 0; j < 4; j++) lq[c][j] = '0;
    end
  endtask

  task automatic add_row(input int c, input logic [31:0] v, input logic [31:0] inc);
    vq[c] = 1'b1;
    for (int j = 0; j < 4; j++) lq[c][j] = v + inc * j;
  endtask

  task automatic mdl_start();
    m_row = 0;
    m_act = 1'b1;
  endtask

  task automatic mdl_row(input logic [31:0] v, input logic [31:0] inc);
    if (m_act) begin
      for (int j = 0; j < 4; j++) begin
`ifdef GEMM_ACCUM_EN
        exp_mem[m_row*4+j] = exp_mem[m_row*4+j] + v + inc * j;
`else
        exp_mem[m_row*4+j] = v + inc * j;
`endif
      end
      m_row++;
      if (m_row == 4) m_act = 1'b0;
    end
  endtask

  task automatic mdl_reset();
    for (int a = 0; a < 16; a++) exp_mem[a] = '0;
    m_act = 1'b0;
    m_row = 0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic play(input int n, input int rst_cyc, input int rd_cyc, input int rd_a);
    for (int c = 0; c < n; c++) begin
      rst_n        = (c != rst_cyc);
      bus.in_valid = vq[c];
      bus.d0       = lq[c][0];
      bus.d1       = (c >= 1) ? lq[c-1][1] : 32'h0;
      bus.d2       = (c >= 2) ? lq[c-2][2] : 32'h0;
      bus.d3       = (c >= 3) ? lq[c-3][3] : 32'h0;
      bus.rd_en    = (c == rd_cyc);
      bus.rd_addr  = 4'(rd_a);
      step();
      done_log[c] = bus.done;
      busy_log[c] = bus.busy;
    end
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    bus.rd_en    = 1'b0;
    bus.d0 = '0; bus.d1 = '0; bus.d2 = '0; bus.d3 = '0;
  endtask

  task automatic rd(input int a, input logic [31:0] exp, input string tag);
    bus.rd_en   = 1'b1;
    bus.rd_addr = 4'(a);
    step();
    bus.rd_en = 1'b0;
    chk(tag, bus.rd_data, exp);
  endtask

  task automatic chk_all(input string tag);
    for (int a = 0; a < 16; a++) rd(a, exp_mem[a], $sformatf("%s_m%0d", tag, a));
  endtask

  initial begin
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.rd_en = 1'b0; bus.rd_addr = '0;
    bus.d0 = '0; bus.d1 = '0; bus.d2 = '0; bus.d3 = '0;
    rst_n = 1'b0;
    mdl_reset();
    step(); step();
    rst_n = 1'b1;
    step();
    // 1: reset state
    chk("t1_busy", 32'(bus.busy), 32'h0);
    chk("t1_done", 32'(bus.done), 32'h0);
    chk("t1_rd", bus.rd_data, 32'h0);
    chk_all("t1");
    // 2: back-to-back rows, read of row being written returns old value
    mdl_start(); pulse_start(); clr();
    for (int r = 0; r < 4; r++) begin
      add_row(r, 32'h100 * r, 32'h1);
      mdl_row(32'h100 * r, 32'h1);
    end
    play(8, -1, 6, 12);
    chk("t2_rdw_old", bus.rd_data, 32'h0);
    chk("t2_busy0", 32'(busy_log[0]), 32'h1);
    chk("t2_done5", 32'(done_log[5]), 32'h0);
    chk("t2_done6", 32'(done_log[6]), 32'h1);
    chk("t2_busy6", 32'(busy_log[6]), 32'h0);
    chk_all("t2");
    rd(6, 32'h102, "t2_a6");
    bus.rd_addr = 4'd3;
    step();
    chk("t2_hold", bus.rd_data, 32'h102);
    // 3: gapped rows plus a dropped fifth row
    mdl_start(); pulse_start(); clr();
    for (int r = 0; r < 4; r++) begin
      add_row(3 * r, 32'h100 * r, 32'h1);
      mdl_row(32'h100 * r, 32'h1);
    end
    add_row(12, 32'hDEAD, 32'h0);
    mdl_row(32'hDEAD, 32'h0);
    play(18, -1, -1, 0);
    chk("t3_done11", 32'(done_log[11]), 32'h0);
    chk("t3_done12", 32'(done_log[12]), 32'h1);
    chk("t3_done_end", 32'(bus.done), 32'h1);
    chk("t3_busy_end", 32'(bus.busy), 32'h0);
    chk_all("t3");
    // 4: restart after two rows
    mdl_start(); pulse_start(); clr();
    for (int r = 0; r < 2; r++) begin
      add_row(r, 32'h5000 + 32'h300 * r, 32'h1);
      mdl_row(32'h5000 + 32'h300 * r, 32'h1);
    end
    play(6, -1, -1, 0);
    chk("t4_busy_mid", 32'(busy_log[5]), 32'h1);
    chk("t4_done_mid", 32'(done_log[5]), 32'h0);
    mdl_start(); pulse_start(); clr();
    for (int r = 0; r < 4; r++) begin
      add_row(r, 32'h200 * r, 32'h1);
      mdl_row(32'h200 * r, 32'h1);
    end
    play(8, -1, -1, 0);
    chk("t4_done", 32'(bus.done), 32'h1);
    chk_all("t4");
    // 5: reset mid-collection, then valid without start is ignored
    mdl_start(); pulse_start(); clr();
    for (int r = 0; r < 3; r++) add_row(r, 32'h700 * r, 32'h1);
    play(5, 4, -1, 0);
    mdl_reset();
    chk("t5_busy", 32'(bus.busy), 32'h0);
    chk("t5_done", 32'(bus.done), 32'h0);
    chk("t5_rd", bus.rd_data, 32'h0);
    clr();
    add_row(0, 32'h999, 32'h1);
    mdl_row(32'h999, 32'h1);
    play(6, -1, -1, 0);
    chk("t5_idle_busy", 32'(bus.busy), 32'h0);
    chk_all("t5");
    // 6: three passes 0xFFFFFFFF, 0xFFFFFFFF, 2
    for (int p = 0; p < 3; p++) begin
      mdl_start(); pulse_start(); clr();
      for (int r = 0; r < 4; r++) begin
        add_row(r, (p == 2) ? 32'h2 : 32'hFFFF_FFFF, 32'h0);
        mdl_row((p == 2) ? 32'h2 : 32'hFFFF_FFFF, 32'h0);
      end
      play(8, -1, -1, 0);
    end
    chk_all("t6");
`ifdef GEMM_ACCUM_EN
    rd(5, 32'h0, "t6_a5");
`else
    rd(5, 32'h2, "t6_a5");
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
